decode_stage: RTL and testbench

- Registered RV32/RV64 instruction decode stage. Sits between the fetch queue and the register-read/issue stage.
- Extracts the instruction fields and builds the sign-extended immediate for every base format (I/S/B/U/J) at a parametrised XLEN.
- Flags illegal encodings and carries the PC alongside the instruction.
- valid/ready handshake on both sides, with a 2-entry skid buffer so in_ready is a pure register output.

---
 rtl/rv_decode_pkg.sv | 47 ++++
 rtl/decode_stage_if.sv | 35 +++
 rtl/imm_gen.sv | 49 ++++
 rtl/decode_stage.sv | 132 +++++++++++++
 tb/tb_decode_stage.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/rv_decode_pkg.sv
// Shared decode definitions: RV opcodes, immediate formats and the decoded-entry payload.
package rv_decode_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } imm_fmt_e;

  // Field order mirrors the instruction word, so a plain cast splits it.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_fields_t;

  typedef struct packed {
    instr_fields_t f;
    logic          imm_valid;
    logic          illegal;
  } decoded_t;

  function automatic instr_fields_t split_fields(input logic [31:0] instr);
    return instr_fields_t'(instr);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Upstream/downstream handshake bundle of the decode stage.
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic            out_imm_valid;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_imm, out_imm_valid, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_imm, out_imm_valid, out_illegal
  );
endinterface

// File: rtl/imm_gen.sv
// Combinational format classification and sign-extended immediate build for one instruction.
module imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm,
  output logic            imm_valid,
  output logic            illegal
);

  logic signed [31:0] imm32;

  always_comb begin
    fmt = FMT_NONE;
    case (instr[6:0])
      OP_IMM, LOAD, JALR, SYSTEM: fmt = FMT_I;
      STORE:                      fmt = FMT_S;
      BRANCH:                     fmt = FMT_B;
      LUI, AUIPC:                 fmt = FMT_U;
      JAL:                        fmt = FMT_J;
      OP:                         fmt = FMT_R;
      OP_IMM_32:                  fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
      OP_32:                      fmt = (XLEN == 64) ? FMT_R : FMT_NONE;
      default:                    fmt = FMT_NONE;
    endcase

    illegal = (instr[1:0] != 2'b11) || (fmt == FMT_NONE);

    imm32 = '0;
    if (!illegal) begin
      case (fmt)
        FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
        FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        FMT_U:   imm32 = {instr[31:12], 12'b0};
        FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        default: imm32 = '0;
      endcase
    end

    imm_valid = !illegal && (fmt != FMT_R);
    // Signed source, so widening to 64 bits replicates instr[31] (U-type included).
    imm = XLEN'(imm32);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32/RV64 decode stage: head register plus one skid entry, in_ready registered.
//
// state    | meaning
// ST_EMPTY | no decoded entry held
// ST_HEAD  | head holds an entry, skid empty
// ST_FULL  | head and skid both hold entries; upstream stalled
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] imm;
    decoded_t        d;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HEAD,
    ST_FULL
  } state_e;

  state_e          state_q, state_d;
  logic            ready_q;
  entry_t          head_q, skid_q, dec_entry;
  logic            load_head, head_from_skid, load_skid;
  logic            in_fire, out_fire;

  imm_fmt_e        gen_fmt;
  logic [XLEN-1:0] gen_imm;
  logic            gen_imm_valid;
  logic            gen_illegal;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr     (bus.in_instr),
    .fmt       (gen_fmt),
    .imm       (gen_imm),
    .imm_valid (gen_imm_valid),
    .illegal   (gen_illegal)
  );

  always_comb begin
    dec_entry             = '0;
    dec_entry.pc          = bus.in_pc;
    dec_entry.imm         = gen_imm;
    dec_entry.d.f         = split_fields(bus.in_instr);
    dec_entry.d.imm_valid = gen_imm_valid && (gen_fmt != FMT_R);
    dec_entry.d.illegal   = gen_illegal;
  end

  assign in_fire  = bus.in_valid && ready_q;
  assign out_fire = (state_q != ST_EMPTY) && bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          load_head = 1'b1;
          state_d   = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (out_fire) begin
          load_head = in_fire;
          state_d   = in_fire ? ST_HEAD : ST_EMPTY;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          head_from_skid = 1'b1;
          state_d        = ST_HEAD;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush discards everything, including an input accepted on the same edge.
    if (bus.flush) begin
      state_d        = ST_EMPTY;
      load_head      = 1'b0;
      head_from_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_FULL);
      if (load_head) begin
        head_q <= dec_entry;
      end else if (head_from_skid) begin
        head_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec_entry;
      end
    end
  end

  assign bus.in_ready      = ready_q;
  assign bus.out_valid     = (state_q != ST_EMPTY);
  assign bus.out_pc        = head_q.pc;
  assign bus.out_opcode    = head_q.d.f.opcode;
  assign bus.out_funct3    = head_q.d.f.funct3;
  assign bus.out_funct7    = head_q.d.f.funct7;
  assign bus.out_rd        = head_q.d.f.rd;
  assign bus.out_rs1       = head_q.d.f.rs1;
  assign bus.out_rs2       = head_q.d.f.rs2;
  assign bus.out_imm       = head_q.imm;
  assign bus.out_imm_valid = head_q.d.imm_valid;
  assign bus.out_illegal   = head_q.d.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage at XLEN=32 and XLEN=64: vector table plus handshake sequences.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .PC_W(32)) b32 ();
  decode_stage_if #(.XLEN(64), .PC_W(32)) b64 ();

  decode_stage #(.XLEN(32), .PC_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  decode_stage #(.XLEN(64), .PC_W(32)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        wide;
    logic [31:0] instr;
    logic [63:0] imm;
    logic        imm_valid;
    logic        illegal;
    logic [4:0]  rd;
    logic [4:0]  rs1;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic wide, input logic valid, input logic [31:0] instr,
                       input logic [31:0] pc);
    b32.in_valid = 1'b0;
    b64.in_valid = 1'b0;
    if (wide) begin
      b64.in_valid = valid; b64.in_instr = instr; b64.in_pc = pc;
    end else begin
      b32.in_valid = valid; b32.in_instr = instr; b32.in_pc = pc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input vec_t v, input int idx, input logic [31:0] pc);
    logic [63:0] imm;
    logic        ov, iv, il;
    logic [4:0]  rd, rs1;
    logic [31:0] opc;
    string       tag;
    tag = $sformatf("vec%0d", idx);
    if (v.wide) begin
      imm = b64.out_imm; ov = b64.out_valid; iv = b64.out_imm_valid; il = b64.out_illegal;
      rd = b64.out_rd; rs1 = b64.out_rs1; opc = b64.out_pc;
    end else begin
      imm = 64'(b32.out_imm); ov = b32.out_valid; iv = b32.out_imm_valid; il = b32.out_illegal;
      rd = b32.out_rd; rs1 = b32.out_rs1; opc = b32.out_pc;
    end
    chk({tag, "_valid"}, 64'(ov), 64'd1);
    chk({tag, "_imm"}, imm, v.imm);
    chk({tag, "_imm_valid"}, 64'(iv), 64'(v.imm_valid));
    chk({tag, "_illegal"}, 64'(il), 64'(v.illegal));
    chk({tag, "_rd"}, 64'(rd), 64'(v.rd));
    chk({tag, "_rs1"}, 64'(rs1), 64'(v.rs1));
    chk({tag, "_pc"}, 64'(opc), 64'(pc));
  endtask

  initial begin
    //        wide  instr         imm                    iv    il    rd     rs1
    vecs[0]  = '{1'b0, 32'hFFF00093, 64'h00000000FFFFFFFF, 1'b1, 1'b0, 5'd1,  5'd0};
    vecs[1]  = '{1'b0, 32'h123452B7, 64'h0000000012345000, 1'b1, 1'b0, 5'd5,  5'd8};
    vecs[2]  = '{1'b0, 32'h00000463, 64'h0000000000000008, 1'b1, 1'b0, 5'd8,  5'd0};
    vecs[3]  = '{1'b0, 32'hFFDFF06F, 64'h00000000FFFFFFFC, 1'b1, 1'b0, 5'd0,  5'd31};
    vecs[4]  = '{1'b0, 32'hFE20AE23, 64'h00000000FFFFFFFC, 1'b1, 1'b0, 5'd28, 5'd1};
    vecs[5]  = '{1'b0, 32'h00001017, 64'h0000000000001000, 1'b1, 1'b0, 5'd0,  5'd0};
    vecs[6]  = '{1'b0, 32'h002081B3, 64'h0000000000000000, 1'b0, 1'b0, 5'd3,  5'd1};
    vecs[7]  = '{1'b0, 32'h00000000, 64'h0000000000000000, 1'b0, 1'b1, 5'd0,  5'd0};
    vecs[8]  = '{1'b0, 32'h0000007F, 64'h0000000000000000, 1'b0, 1'b1, 5'd0,  5'd0};
    vecs[9]  = '{1'b0, 32'h0010009B, 64'h0000000000000000, 1'b0, 1'b1, 5'd1,  5'd0};
    vecs[10] = '{1'b1, 32'h800000B7, 64'hFFFFFFFF80000000, 1'b1, 1'b0, 5'd1,  5'd0};
    vecs[11] = '{1'b1, 32'h0010009B, 64'h0000000000000001, 1'b1, 1'b0, 5'd1,  5'd0};
    vecs[12] = '{1'b1, 32'h002081BB, 64'h0000000000000000, 1'b0, 1'b0, 5'd3,  5'd1};
    vecs[13] = '{1'b1, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 5'd1,  5'd0};

    b32.flush = 1'b0; b32.out_ready = 1'b1; b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_pc = '0;
    b64.flush = 1'b0; b64.out_ready = 1'b1; b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_pc = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
    chk("rst_out_imm", 64'(b32.out_imm), 64'd0);
    chk("rst_out_pc", 64'(b32.out_pc), 64'd0);
    chk("rst64_out_valid", 64'(b64.out_valid), 64'd0);
    chk("rst64_in_ready", 64'(b64.in_ready), 64'd1);
    rst = 1'b0;
    step();

    // Back-to-back: each cycle the head is replaced by the instruction accepted on that edge.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].wide, 1'b1, vecs[i].instr, 32'h100 + 32'(4 * i));
      step();
      check_vec(vecs[i], i, 32'h100 + 32'(4 * i));
    end
    drive(1'b0, 1'b0, '0, '0);
    step();
    chk("drain32_valid", 64'(b32.out_valid), 64'd0);
    chk("drain64_valid", 64'(b64.out_valid), 64'd0);

    // Backpressure: A to head, B to skid, C held upstream, then drain in order.
    b32.out_ready = 1'b0;
    drive(1'b0, 1'b1, 32'hFFF00093, 32'h200);
    step();
    chk("bp_ready_c2", 64'(b32.in_ready), 64'd1);
    chk("bp_head_a", 64'(b32.out_pc), 64'h200);
    drive(1'b0, 1'b1, 32'h123452B7, 32'h204);
    step();
    chk("bp_ready_c3", 64'(b32.in_ready), 64'd0);
    chk("bp_hold_a", 64'(b32.out_pc), 64'h200);
    drive(1'b0, 1'b1, 32'hFFDFF06F, 32'h208);
    step();
    chk("bp_ready_c4", 64'(b32.in_ready), 64'd0);
    chk("bp_stable_pc", 64'(b32.out_pc), 64'h200);
    chk("bp_stable_imm", 64'(b32.out_imm), 64'hFFFFFFFF);
    chk("bp_stable_rd", 64'(b32.out_rd), 64'd1);
    b32.out_ready = 1'b1;
    step();
    chk("bp_out_b_pc", 64'(b32.out_pc), 64'h204);
    chk("bp_out_b_imm", 64'(b32.out_imm), 64'h12345000);
    chk("bp_out_b_valid", 64'(b32.out_valid), 64'd1);
    chk("bp_ready_back", 64'(b32.in_ready), 64'd1);
    step();
    chk("bp_out_c_pc", 64'(b32.out_pc), 64'h208);
    chk("bp_out_c_imm", 64'(b32.out_imm), 64'hFFFFFFFC);
    chk("bp_out_c_valid", 64'(b32.out_valid), 64'd1);
    drive(1'b0, 1'b0, '0, '0);
    step();
    chk("bp_empty", 64'(b32.out_valid), 64'd0);

    // Flush with both entries full and a third instruction presented on the flush edge.
    b32.out_ready = 1'b0;
    drive(1'b0, 1'b1, 32'h00001017, 32'h300);
    step();
    drive(1'b0, 1'b1, 32'hFE20AE23, 32'h304);
    step();
    chk("fl_full_ready", 64'(b32.in_ready), 64'd0);
    drive(1'b0, 1'b1, 32'h0000007F, 32'h308);
    b32.flush = 1'b1;
    step();
    chk("fl_out_valid", 64'(b32.out_valid), 64'd0);
    chk("fl_in_ready", 64'(b32.in_ready), 64'd1);
    b32.flush = 1'b0;
    b32.out_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("fl_gone%0d", c), 64'(b32.out_valid), 64'd0);
    end
    drive(1'b0, 1'b1, 32'h002081B3, 32'h30C);
    step();
    chk("fl_after_valid", 64'(b32.out_valid), 64'd1);
    chk("fl_after_pc", 64'(b32.out_pc), 64'h30C);
    chk("fl_after_rd", 64'(b32.out_rd), 64'd3);
    drive(1'b0, 1'b0, '0, '0);
    step();

    // Reset mid-stream with both entries full; rst wins over a presented input.
    b32.out_ready = 1'b0;
    drive(1'b0, 1'b1, 32'h123452B7, 32'h400);
    step();
    drive(1'b0, 1'b1, 32'h00000463, 32'h404);
    step();
    chk("rs_full_ready", 64'(b32.in_ready), 64'd0);
    drive(1'b0, 1'b1, 32'hFFDFF06F, 32'h408);
    rst = 1'b1;
    step();
    chk("rs_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rs_in_ready", 64'(b32.in_ready), 64'd1);
    chk("rs_out_pc", 64'(b32.out_pc), 64'd0);
    chk("rs_out_imm", 64'(b32.out_imm), 64'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    b32.out_ready = 1'b1;
    step();
    chk("rs_stays_empty", 64'(b32.out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
